instr_loader: RTL and testbench

Boot-time program loader directly upstream of the single-cycle CPU's instruction memory. It accepts a byte stream over a valid/ready handshake, assembles big-endian 32-bit words, and writes them sequentially into the instruction memory write port. While loading, it holds the CPU in reset and releases it only after a complete, well-formed image has been written.

---
 rtl/instr_loader_if.sv | 24 ++
 rtl/instr_loader.sv | 156 +++++++++++++++
 tb/tb_instr_loader.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_loader_if.sv
// Byte-stream input and instruction-memory write port of the boot loader.
// Handshake: a byte moves on any rising edge where byte_valid_i && byte_ready_o; ready never depends on valid.
interface instr_loader_if;
  logic        start_i;
  logic [7:0]  byte_i;
  logic        byte_valid_i;
  logic        byte_ready_o;
  logic        wr_en_o;
  logic [31:0] wr_addr_o;
  logic [31:0] wr_data_o;
  logic        cpu_hold_o;
  logic        done_o;
  logic        err_o;

  modport master (
    output start_i, byte_i, byte_valid_i,
    input  byte_ready_o, wr_en_o, wr_addr_o, wr_data_o, cpu_hold_o, done_o, err_o
  );

  modport slave (
    input  start_i, byte_i, byte_valid_i,
    output byte_ready_o, wr_en_o, wr_addr_o, wr_data_o, cpu_hold_o, done_o, err_o
  );
endinterface

// File: rtl/instr_loader.sv
// Boot loader: length-prefixed big-endian byte stream -> sequential instruction-memory writes.
// Optional trailing XOR checksum byte when LOADER_CHECKSUM_EN is defined.
module instr_loader #(
    parameter int          MAX_WORDS = 256,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic           clk_i,
    input  logic           rst_i,
    instr_loader_if.slave  bus,
    output logic [2:0]     dbg_state_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_HI,
        S_LEN_LO,
        S_DATA,
        S_DONE,
        S_ERR
`ifdef LOADER_CHECKSUM_EN
        , S_CHK
`endif
    } state_t;

    // State entered once the length or last data word has been consumed.
`ifdef LOADER_CHECKSUM_EN
    localparam state_t S_TAIL = S_CHK;
`else
    localparam state_t S_TAIL = S_DONE;
`endif

    localparam logic [15:0] MAX_N = 16'(MAX_WORDS);

    state_t      state_q, state_n;
    logic [15:0] len_q;
    logic [15:0] idx_q;
    logic [1:0]  bcnt_q;
    logic [23:0] asm_q;
    logic        wr_en_q;
    logic [31:0] wr_addr_q;
    logic [31:0] wr_data_q;
    logic        xfer;
    logic [15:0] len_n;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]  csum_q;
`endif

    assign xfer  = bus.byte_valid_i && bus.byte_ready_o;
    assign len_n = {len_q[15:8], bus.byte_i};

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= S_IDLE;
        else       state_q <= state_n;
    end

    always_comb begin
        state_n          = state_q;
        bus.byte_ready_o = 1'b0;
        bus.done_o       = 1'b0;
        bus.err_o        = 1'b0;
        bus.cpu_hold_o   = 1'b1;
        case (state_q)
            S_IDLE: begin
                if (bus.start_i) state_n = S_LEN_HI;
            end
            S_LEN_HI: begin
                bus.byte_ready_o = 1'b1;
                if (xfer) state_n = S_LEN_LO;
            end
            S_LEN_LO: begin
                bus.byte_ready_o = 1'b1;
                if (xfer) begin
                    if (len_n == 16'd0)      state_n = S_TAIL;
                    else if (len_n > MAX_N)  state_n = S_ERR;
                    else                     state_n = S_DATA;
                end
            end
            S_DATA: begin
                bus.byte_ready_o = 1'b1;
                if (xfer && bcnt_q == 2'd3 && idx_q == len_q - 16'd1) state_n = S_TAIL;
            end
`ifdef LOADER_CHECKSUM_EN
            S_CHK: begin
                bus.byte_ready_o = 1'b1;
                if (xfer) state_n = (bus.byte_i == csum_q) ? S_DONE : S_ERR;
            end
`endif
            S_DONE: begin
                bus.done_o     = 1'b1;
                bus.cpu_hold_o = 1'b0;
                if (bus.start_i) state_n = S_LEN_HI;
            end
            S_ERR: begin
                bus.err_o = 1'b1;
                if (bus.start_i) state_n = S_LEN_HI;
            end
            default: state_n = S_IDLE;
        endcase
    end

    // Word assembly and write port; the strobe lands in the cycle after the 4th byte.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            len_q     <= 16'd0;
            idx_q     <= 16'd0;
            bcnt_q    <= 2'd0;
            asm_q     <= 24'd0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= 32'd0;
            wr_data_q <= 32'd0;
        end else begin
            wr_en_q <= 1'b0;
            case (state_q)
                S_LEN_HI: if (xfer) len_q[15:8] <= bus.byte_i;
                S_LEN_LO: begin
                    if (xfer) begin
                        len_q[7:0] <= bus.byte_i;
                        idx_q      <= 16'd0;
                        bcnt_q     <= 2'd0;
                    end
                end
                S_DATA: begin
                    if (xfer) begin
                        asm_q  <= {asm_q[15:0], bus.byte_i};
                        bcnt_q <= bcnt_q + 2'd1;
                        if (bcnt_q == 2'd3) begin
                            wr_en_q   <= 1'b1;
                            wr_data_q <= {asm_q, bus.byte_i};
                            wr_addr_q <= BASE_ADDR + {14'd0, idx_q, 2'b00};
                            idx_q     <= idx_q + 16'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef LOADER_CHECKSUM_EN
    // Running XOR over length and data bytes; restarted on every new load.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            csum_q <= 8'd0;
        else if (state_n == S_LEN_HI && state_q != S_LEN_HI)
            csum_q <= 8'd0;
        else if (xfer && state_q != S_CHK)
            csum_q <= csum_q ^ bus.byte_i;
    end
`endif

    assign bus.wr_en_o   = wr_en_q;
    assign bus.wr_addr_o = wr_addr_q;
    assign bus.wr_data_o = wr_data_q;
    assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_instr_loader.sv
// Bench for instr_loader: images built from the stream rules, writes collected and compared.
// Build with +define+LOADER_CHECKSUM_EN to cover the checksum variant.
module tb_instr_loader;
  localparam int          MAX_WORDS = 256;
  localparam logic [31:0] BASE_ADDR = 32'h0000_0000;

  logic       clk;
  logic       rst;
  logic [2:0] dbg_state;
  int         total;
  int         bad;
  int         exp_done;
  int         exp_err;

  logic [63:0] exp_q[$];
  logic [63:0] act_q[$];
  logic [7:0]  tx_q[$];

  instr_loader_if bus ();

  instr_loader #(.MAX_WORDS(MAX_WORDS), .BASE_ADDR(BASE_ADDR)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // write monitor
  always @(negedge clk) begin
    if (bus.wr_en_o === 1'b1) act_q.push_back({bus.wr_addr_o, bus.wr_data_o});
  end

  // reference model: stream bytes, expected writes and final status
  task automatic build_image(input logic [15:0] n, input bit corrupt, input bit fixed);
    logic [7:0]  cs;
    logic [31:0] w;
    logic [31:0] fixed_w[2];
    fixed_w[0] = 32'h2008_0005;
    fixed_w[1] = 32'h8C01_0004;
    tx_q.delete();
    exp_q.delete();
    tx_q.push_back(n[15:8]);
    tx_q.push_back(n[7:0]);
    cs = n[15:8] ^ n[7:0];
    if (int'(n) > MAX_WORDS) begin
      exp_done = 0;
      exp_err  = 1;
      return;
    end
    for (int i = 0; i < int'(n); i++) begin
      w = (fixed && i < 2) ? fixed_w[i] : $urandom;
      tx_q.push_back(w[31:24]);
      tx_q.push_back(w[23:16]);
      tx_q.push_back(w[15:8]);
      tx_q.push_back(w[7:0]);
      cs = cs ^ w[31:24] ^ w[23:16] ^ w[15:8] ^ w[7:0];
      exp_q.push_back({BASE_ADDR + 32'(4 * i), w});
    end
    exp_done = 1;
    exp_err  = 0;
`ifdef LOADER_CHECKSUM_EN
    tx_q.push_back(corrupt ? (cs ^ 8'hFF) : cs);
    if (corrupt) begin
      exp_done = 0;
      exp_err  = 1;
    end
`endif
  endtask

  // driver tasks
  task automatic pulse_start();
    @(negedge clk);
    bus.start_i = 1'b1;
    @(negedge clk);
    bus.start_i = 1'b0;
  endtask

  // mode 0: every cycle, 1: valid toggles, 2: random gaps; sends the first cnt bytes
  task automatic send_stream(input int mode, input int cnt);
    bit tog;
    bit sent;
    bit v;
    int budget;
    tog = 1'b1;
    for (int k = 0; k < cnt; k++) begin
      sent   = 1'b0;
      budget = 0;
      while (!sent) begin
        @(negedge clk);
        v = (mode == 0) ? 1'b1 : (mode == 1) ? tog : 1'($urandom_range(0, 1));
        tog = ~tog;
        bus.byte_valid_i = v;
        bus.byte_i       = v ? tx_q[k] : 8'($urandom);
        if (v && bus.byte_ready_o === 1'b1) sent = 1'b1;
        budget++;
        if (!sent && budget > 50) begin
          total++;
          bad++;
          $display("FAIL stream_stall byte=%0d got ready=%b want 1", k, bus.byte_ready_o);
          bus.byte_valid_i = 1'b0;
          return;
        end
      end
    end
    @(posedge clk);
    #1;
    bus.byte_valid_i = 1'b0;
  endtask

  task automatic test_reset();
    bus.start_i      = 1'b0;
    bus.byte_i       = 8'h00;
    bus.byte_valid_i = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    act_q.delete();
    repeat (4) @(negedge clk);
    total++; if (bus.cpu_hold_o !== 1'b1) begin bad++; $display("FAIL reset_hold got=%b want=1", bus.cpu_hold_o); end
    total++; if (bus.byte_ready_o !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b want=0", bus.byte_ready_o); end
    total++; if (bus.done_o !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", bus.done_o); end
    total++; if (bus.err_o !== 1'b0) begin bad++; $display("FAIL reset_err got=%b want=0", bus.err_o); end
    total++; if (bus.wr_addr_o !== 32'd0 || bus.wr_data_o !== 32'd0) begin
      bad++; $display("FAIL reset_wr_bus got=%h/%h want=0/0", bus.wr_addr_o, bus.wr_data_o);
    end
    total++; if (act_q.size() != 0) begin bad++; $display("FAIL reset_no_write got=%0d want=0", act_q.size()); end
  endtask

  task automatic test_basic();
    act_q.delete();
    build_image(16'd2, 1'b0, 1'b1);
    pulse_start();
    total++; if (bus.cpu_hold_o !== 1'b1 || bus.byte_ready_o !== 1'b1) begin
      bad++; $display("FAIL basic_loading got hold=%b ready=%b want 1/1", bus.cpu_hold_o, bus.byte_ready_o);
    end
    send_stream(0, tx_q.size());
    @(negedge clk);
    total++; if (bus.done_o !== 1'b1 || bus.cpu_hold_o !== 1'b0) begin
      bad++; $display("FAIL basic_done_timing got done=%b hold=%b want 1/0", bus.done_o, bus.cpu_hold_o);
    end
`ifndef LOADER_CHECKSUM_EN
    total++; if (bus.wr_en_o !== 1'b1) begin bad++; $display("FAIL basic_last_write_with_done got=%b want=1", bus.wr_en_o); end
`endif
    repeat (2) @(negedge clk);
    total++; if (bus.byte_ready_o !== 1'b0 || bus.err_o !== 1'b0) begin
      bad++; $display("FAIL basic_idle got ready=%b err=%b want 0/0", bus.byte_ready_o, bus.err_o);
    end
    total++; if (act_q.size() != 2) begin bad++; $display("FAIL basic_count got=%0d want=2", act_q.size()); end
    else begin
      total++; if (act_q[0] !== 64'h0000_0000_2008_0005) begin bad++; $display("FAIL basic_w0 got=%h want=0000000020080005", act_q[0]); end
      total++; if (act_q[1] !== 64'h0000_0004_8C01_0004) begin bad++; $display("FAIL basic_w1 got=%h want=000000048c010004", act_q[1]); end
    end
  endtask

  task automatic test_toggle_valid();
    act_q.delete();
    build_image(16'd2, 1'b0, 1'b1);
    pulse_start();
    send_stream(1, tx_q.size());
    repeat (3) @(negedge clk);
    total++; if (bus.done_o !== 1'b1) begin bad++; $display("FAIL toggle_done got=%b want=1", bus.done_o); end
    total++; if (act_q.size() != exp_q.size()) begin bad++; $display("FAIL toggle_count got=%0d want=%0d", act_q.size(), exp_q.size()); end
    else foreach (exp_q[k]) begin
      total++; if (act_q[k] !== exp_q[k]) begin bad++; $display("FAIL toggle_w%0d got=%h want=%h", k, act_q[k], exp_q[k]); end
    end
  endtask

  task automatic test_oversize();
    act_q.delete();
    build_image(16'h0101, 1'b0, 1'b0);
    pulse_start();
    send_stream(0, tx_q.size());
    @(negedge clk);
    total++; if (bus.err_o !== 1'b1 || bus.done_o !== 1'b0) begin
      bad++; $display("FAIL oversize_err got err=%b done=%b want 1/0", bus.err_o, bus.done_o);
    end
    total++; if (bus.cpu_hold_o !== 1'b1 || bus.byte_ready_o !== 1'b0) begin
      bad++; $display("FAIL oversize_hold got hold=%b ready=%b want 1/0", bus.cpu_hold_o, bus.byte_ready_o);
    end
    repeat (3) @(negedge clk);
    total++; if (act_q.size() != 0) begin bad++; $display("FAIL oversize_no_write got=%0d want=0", act_q.size()); end
  endtask

  task automatic test_zero_len();
    act_q.delete();
    build_image(16'd0, 1'b0, 1'b0);
    pulse_start();
    send_stream(2, tx_q.size());
    repeat (2) @(negedge clk);
    total++; if (bus.done_o !== 1'b1 || bus.cpu_hold_o !== 1'b0) begin
      bad++; $display("FAIL zero_done got done=%b hold=%b want 1/0", bus.done_o, bus.cpu_hold_o);
    end
    total++; if (act_q.size() != 0) begin bad++; $display("FAIL zero_no_write got=%0d want=0", act_q.size()); end
  endtask

  task automatic test_reset_mid_load();
    act_q.delete();
    build_image(16'd2, 1'b0, 1'b1);
    pulse_start();
    send_stream(0, 5);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    total++; if (bus.cpu_hold_o !== 1'b1 || bus.byte_ready_o !== 1'b0 || bus.wr_en_o !== 1'b0) begin
      bad++; $display("FAIL midrst_state got hold=%b ready=%b wr=%b want 1/0/0", bus.cpu_hold_o, bus.byte_ready_o, bus.wr_en_o);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    total++; if (act_q.size() != 0 || bus.cpu_hold_o !== 1'b1) begin
      bad++; $display("FAIL midrst_partial got writes=%0d hold=%b want 0/1", act_q.size(), bus.cpu_hold_o);
    end
    build_image(16'd3, 1'b0, 1'b0);
    pulse_start();
    send_stream(0, tx_q.size());
    repeat (2) @(negedge clk);
    total++; if (bus.done_o !== 1'b1) begin bad++; $display("FAIL midrst_done got=%b want=1", bus.done_o); end
    total++; if (act_q.size() != exp_q.size()) begin bad++; $display("FAIL midrst_count got=%0d want=%0d", act_q.size(), exp_q.size()); end
    else foreach (exp_q[k]) begin
      total++; if (act_q[k] !== exp_q[k]) begin bad++; $display("FAIL midrst_w%0d got=%h want=%h", k, act_q[k], exp_q[k]); end
    end
  endtask

  // repeated loads straight from DONE/ERR, random lengths and pacing
  task automatic test_back_to_back();
    int n;
    int mode;
    for (int r = 0; r < 6; r++) begin
      act_q.delete();
      n    = $urandom_range(1, 9);
      mode = $urandom_range(0, 2);
      build_image(16'(n), 1'b0, 1'b0);
      @(negedge clk);
      bus.byte_valid_i = 1'b1;
      bus.byte_i       = 8'hA5;
      total++; if (bus.byte_ready_o !== 1'b0) begin bad++; $display("FAIL b2b_ready_in_final r=%0d got=%b want=0", r, bus.byte_ready_o); end
      bus.start_i = 1'b1;
      @(negedge clk);
      bus.start_i      = 1'b0;
      bus.byte_valid_i = 1'b0;
      send_stream(mode, tx_q.size());
      repeat (2) @(negedge clk);
      total++; if (bus.done_o !== 1'(exp_done) || bus.err_o !== 1'(exp_err)) begin
        bad++; $display("FAIL b2b_status r=%0d got done=%b err=%b want %0d/%0d", r, bus.done_o, bus.err_o, exp_done, exp_err);
      end
      total++; if (act_q.size() != exp_q.size()) begin bad++; $display("FAIL b2b_count r=%0d got=%0d want=%0d", r, act_q.size(), exp_q.size()); end
      else foreach (exp_q[k]) begin
        total++; if (act_q[k] !== exp_q[k]) begin bad++; $display("FAIL b2b_w%0d r=%0d got=%h want=%h", k, r, act_q[k], exp_q[k]); end
      end
    end
  endtask

`ifdef LOADER_CHECKSUM_EN
  task automatic test_bad_checksum();
    act_q.delete();
    build_image(16'd2, 1'b1, 1'b1);
    pulse_start();
    send_stream(0, tx_q.size());
    repeat (2) @(negedge clk);
    total++; if (bus.err_o !== 1'b1 || bus.cpu_hold_o !== 1'b1 || bus.done_o !== 1'b0) begin
      bad++; $display("FAIL csum_err got err=%b hold=%b done=%b want 1/1/0", bus.err_o, bus.cpu_hold_o, bus.done_o);
    end
    total++; if (act_q.size() != 2) begin bad++; $display("FAIL csum_count got=%0d want=2", act_q.size()); end
    else foreach (exp_q[k]) begin
      total++; if (act_q[k] !== exp_q[k]) begin bad++; $display("FAIL csum_w%0d got=%h want=%h", k, act_q[k], exp_q[k]); end
    end
  endtask
`endif

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    test_reset();
    test_basic();
    test_toggle_valid();
    test_oversize();
    test_zero_len();
    test_reset_mid_load();
`ifdef LOADER_CHECKSUM_EN
    test_bad_checksum();
`endif
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
